cr_tlvp_tlv_axi_tx: RTL



---
 rtl/cr_tlvp_tlv_axi_tx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cr_tlvp_tlv_axi_tx.sv
// cr_tlvp_tlv_axi_tx: TLV transmit framer, engine-written words -> AXI4-Stream master.
// Latency: usr_wr_i in cycle N -> axi4s_ob_tvalid_o in cycle N+2; sustains 1 word/clk.
// Backpressure: tready stalls the output register, then the FIFO; usr_full_o drops writes.
// Optional macro CR_TLVP_TX_BIP2_EN: per-TLV BIP2 in tuser[7:6] of the closing word.
// Ports: clk/rst_n; usr_* = write side (wr, sot, eot, tlast, typen, data, full, afull);
//        axi4s_ob_* = AXI4-S master; tx_frame_error_o = violation pulse; tx_tlv_cnt_o = TLVs closed.
module cr_tlvp_tlv_axi_tx #(
    parameter int N_ENTRIES   = 16,
    parameter int N_AFULL_VAL = 3,
    parameter int MAX_WORDS   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        usr_wr_i,
    input  logic        usr_sot_i,
    input  logic        usr_eot_i,
    input  logic        usr_tlast_i,
    input  logic [7:0]  usr_typen_i,
    input  logic [63:0] usr_data_i,
    output logic        usr_full_o,
    output logic        usr_afull_o,
    output logic        axi4s_ob_tvalid_o,
    input  logic        axi4s_ob_tready_i,
    output logic        axi4s_ob_tlast_o,
    output logic [7:0]  axi4s_ob_tuser_o,
    output logic [7:0]  axi4s_ob_tstrb_o,
    output logic [63:0] axi4s_ob_tdata_o,
    output logic        tx_frame_error_o,
    output logic [31:0] tx_tlv_cnt_o
);
    localparam int AW = $clog2(N_ENTRIES);
    localparam logic MAX_ONE = (MAX_WORDS == 1);

    typedef struct packed {
        logic        sot;
        logic        eot;
        logic        tlast;
        logic [7:0]  typen;
        logic [63:0] data;
    } word_t;

    typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

    // ---------------- input FIFO ----------------
    word_t         mem_q [N_ENTRIES];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          wr_en, pop, fifo_vld;
    word_t         head;

    assign usr_full_o  = (int'(count_q) == N_ENTRIES);
    assign usr_afull_o = ((N_ENTRIES - int'(count_q)) <= N_AFULL_VAL);
    assign wr_en       = usr_wr_i && !usr_full_o;
    assign fifo_vld    = (count_q != '0);
    // Storage is a register array, so the head word is available straight from it.
    assign head        = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {usr_sot_i, usr_eot_i, usr_tlast_i, usr_typen_i, usr_data_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
        end
    end

    // ---------------- framing FSM ----------------
    state_t        state_q, state_d;
    logic [15:0]   word_cnt_q, word_cnt_d;
    logic [7:0]    typen_q, typen_d;
    logic          out_vld_q, out_last_q, err_q;
    logic [7:0]    out_user_q;
    logic [63:0]   out_dat_q;
    logic [31:0]   tlv_cnt_q;
    logic          out_free, idle_drop, idle_take, body_take, body_close, force_eot;
    logic          load, ld_sot, ld_eot, ld_last, err_d;
    logic [63:0]   ld_dat;
    logic [1:0]    ld_bip;

    assign out_free   = !out_vld_q || axi4s_ob_tready_i;
    assign idle_drop  = (state_q == IDLE) && fifo_vld && !head.sot;
    assign idle_take  = (state_q == IDLE) && fifo_vld &&  head.sot && out_free;
    assign body_take  = (state_q == BODY) && fifo_vld && !head.sot && out_free;
    // A sot arriving mid-TLV stays in the FIFO; a synthetic closing word goes out first.
    assign body_close = (state_q == BODY) && fifo_vld &&  head.sot && out_free;
    // Word about to be emitted is number MAX_WORDS and does not close the TLV itself.
    assign force_eot  = !head.eot && ((idle_take && MAX_ONE) ||
                        (body_take && (word_cnt_q == 16'(MAX_WORDS - 1))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (idle_take && !head.eot && !force_eot) state_d = BODY;
            BODY: if (body_close || (body_take && (head.eot || force_eot))) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop        = idle_drop | idle_take | body_take;
        load       = idle_take | body_take | body_close;
        ld_sot     = idle_take;
        ld_eot     = body_close | head.eot | force_eot;
        ld_last    = body_close ? 1'b0 : head.tlast;
        ld_dat     = body_close ? 64'd0 : head.data;
        err_d      = idle_drop | body_close | force_eot;
        word_cnt_d = word_cnt_q;
        typen_d    = typen_q;
        if (idle_take) begin
            word_cnt_d = 16'd1;
            typen_d    = head.typen;
        end else if (body_take) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

`ifdef CR_TLVP_TX_BIP2_EN
    localparam logic [63:0] EVEN_M = {32{2'b01}};
    localparam logic [63:0] ODD_M  = {32{2'b10}};
    logic [1:0] bip_q, bip_acc, par;

    assign par     = {^(head.data & ODD_M), ^(head.data & EVEN_M)};
    // A sot word restarts the accumulation.
    assign bip_acc = (state_q == IDLE) ? par : (bip_q ^ par);
    // The synthetic closing word carries data 0, so it reports the words before it.
    assign ld_bip  = !ld_eot ? 2'b00 : (body_close ? bip_q : bip_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     bip_q <= 2'b00;
        else if (idle_take | body_take) bip_q <= bip_acc;
    end
`else
    assign ld_bip = 2'b00;
`endif

    // The type has no field in this tuser mapping; it is held for the current TLV only.
    logic unused_typen;
    assign unused_typen = ^typen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
            typen_q    <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_user_q <= '0;
            out_dat_q  <= '0;
            err_q      <= 1'b0;
            tlv_cnt_q  <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            typen_q    <= typen_d;
            err_q      <= err_d;
            if (load) begin
                out_vld_q  <= 1'b1;
                out_last_q <= ld_last;
                out_user_q <= {ld_bip, 4'b0000, ld_eot, ld_sot};
                out_dat_q  <= ld_dat;
            end else if (axi4s_ob_tready_i) begin
                out_vld_q  <= 1'b0;
            end
            // A TLV counts once its closing word is accepted downstream.
            if (out_vld_q && axi4s_ob_tready_i && out_user_q[1]) tlv_cnt_q <= tlv_cnt_q + 32'd1;
        end
    end

    assign axi4s_ob_tvalid_o = out_vld_q;
    assign axi4s_ob_tlast_o  = out_last_q;
    assign axi4s_ob_tuser_o  = out_user_q;
    assign axi4s_ob_tstrb_o  = 8'hff;
    assign axi4s_ob_tdata_o  = out_dat_q;
    assign tx_frame_error_o  = err_q;
    assign tx_tlv_cnt_o      = tlv_cnt_q;
endmodule
